// File: rtl/adder_pkg.sv
// Shared constants and per-stage control flags for the pipelined CLA adder.
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Control part of a stage payload; the data part depends on WIDTH and lives in the top.
    typedef struct packed {
        logic valid;
        logic carry;   // carry out of the slices resolved so far
        logic c_msb;   // carry into the top bit of the last resolved slice
    } stage_ctl_t;

endpackage

// File: rtl/cla_chunk.sv
// Combinational CHUNK-bit generate/propagate lookahead slice.
module cla_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] grp_g;
    logic [CHUNK-1:0] grp_p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Prefix group g/p so every carry is a direct function of cin.
    always_comb begin
        grp_g[0] = g[0];
        grp_p[0] = p[0];
        for (int i = 1; i < CHUNK; i++) begin
            grp_g[i] = g[i] | (p[i] & grp_g[i-1]);
            grp_p[i] = p[i] & grp_p[i-1];
        end
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = grp_g[i] | (grp_p[i] & cin);
        end
    end

    assign sum   = p ^ c[CHUNK-1:0];
    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder/subtractor resolved CHUNK bits per register stage, with a
// global-stall valid/ready pipeline.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;   // already conditionally inverted for subtract
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t           stage_q [STAGES];
    stage_t           stage_d [STAGES];
    stage_t           prev    [STAGES];
    logic [CHUNK-1:0] ch_a    [STAGES];
    logic [CHUNK-1:0] ch_b    [STAGES];
    logic [CHUNK-1:0] ch_s    [STAGES];
    logic             ch_ci   [STAGES];
    logic             ch_co   [STAGES];
    logic             ch_msb  [STAGES];
    logic             stall;

    assign stall    = stage_q[STAGES-1].ctl.valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 0 works straight off the ports; later stages off the previous register.
    always_comb begin
        prev[0].ctl.valid = in_valid;
        prev[0].ctl.carry = sub ? 1'b1 : cin;
        prev[0].ctl.c_msb = 1'b0;
        prev[0].a         = a;
        prev[0].b         = sub ? ~b : b;
        prev[0].s         = '0;
        for (int k = 1; k < STAGES; k++) begin
            prev[k] = stage_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            ch_a[k]  = prev[k].a[k*CHUNK +: CHUNK];
            ch_b[k]  = prev[k].b[k*CHUNK +: CHUNK];
            ch_ci[k] = prev[k].ctl.carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (ch_a[k]),
            .b     (ch_b[k]),
            .cin   (ch_ci[k]),
            .sum   (ch_s[k]),
            .cout  (ch_co[k]),
            .c_msb (ch_msb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                     = prev[k];
            stage_d[k].s[k*CHUNK +: CHUNK] = ch_s[k];
            stage_d[k].ctl.carry           = ch_co[k];
            stage_d[k].ctl.c_msb           = ch_msb[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].ctl.valid;
    assign sum       = stage_q[STAGES-1].s;
    assign cout      = stage_q[STAGES-1].ctl.carry;
    assign ovf       = stage_q[STAGES-1].ctl.carry ^ stage_q[STAGES-1].ctl.c_msb;

endmodule
